// File: rtl/uart_pkg.sv
// UART shared definitions.
// Used by both the receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic par_bit(
    input logic data_xor,
    input logic typ
  );
    return data_xor ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// UART receiver link.
// Serial line and config in, parallel word and status out.
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);

  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err, busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Mid-bit 3-sample majority vote.
// Samples at edges prescale/2-1, prescale/2 and prescale/2+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit
);

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            smp;

  assign half = prescale >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= {3{STOP_BIT}};
    end else begin
      if (edge_cnt == half - PRESCALE_W'(1)) smp[0] <= rx_in;
      if (edge_cnt == half)                  smp[1] <= rx_in;
      if (edge_cnt == half + PRESCALE_W'(1)) smp[2] <= rx_in;
    end
  end

  assign sampled_bit = (smp[0] & smp[1]) |
                       (smp[0] & smp[2]) |
                       (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start detect, oversampled bit timing,
// LSB-first shift, parity/stop check, one-cycle status pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic          clk,
  input logic          rst,
  uart_rx_core_if.slave rx
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = RX_IDLE;
  localparam logic [2:0] S_START  = RX_START;
  localparam logic [2:0] S_DATA   = RX_DATA;
  localparam logic [2:0] S_PARITY = RX_PARITY;
  localparam logic [2:0] S_STOP   = RX_STOP;

  logic [2:0]            state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] pre_q;
  logic [BW-1:0]         bit_cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_flag;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  sampled_bit;
  logic                  last_edge;

  assign last_edge = edge_cnt == pre_q - PRESCALE_W'(1);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx.rx_in),
    .edge_cnt    (edge_cnt),
    .prescale    (pre_q),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      pre_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_flag   <= 1'b0;
      shreg      <= '0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state != S_IDLE)
        edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_W'(1);
      unique case (state)
        S_IDLE: begin
          // the detect cycle is edge 0, so the frame starts at edge 1
          if (rx.rx_in == START_BIT) begin
            state     <= S_START;
            edge_cnt  <= PRESCALE_W'(1);
            bit_cnt   <= '0;
            par_flag  <= 1'b0;
            pre_q     <= rx.prescale;
            par_en_q  <= rx.par_en;
            par_typ_q <= rx.par_typ;
          end
        end
        S_START: begin
          if (last_edge)
            state <= (sampled_bit == START_BIT) ? S_DATA : S_IDLE;
        end
        S_DATA: begin
          if (last_edge) begin
            shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(DATA_WIDTH - 1))
              state <= par_en_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (last_edge) begin
            par_flag <= sampled_bit != par_bit(^shreg, par_typ_q);
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (last_edge) begin
            state   <= S_IDLE;
            par_err <= par_flag;
            stp_err <= sampled_bit != STOP_BIT;
            if (sampled_bit == STOP_BIT && !par_flag) begin
              data_valid <= 1'b1;
              p_data     <= shreg;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx.p_data     = p_data;
  assign rx.data_valid = data_valid;
  assign rx.par_err    = par_err;
  assign rx.stp_err    = stp_err;
  assign rx.busy       = state != S_IDLE;

endmodule
